// File: rtl/grant_burst_mux.sv
// -----------------------------------------------------------------------------
// grant_burst_mux
//
// Purpose:
//   Sits behind a 2-requester arbiter. When a master is granted, this block
//   steers a fixed-length burst of BURST_LEN beats from that master onto one
//   shared valid/ready output port. It signals the end of the burst with
//   done_x so the master drops its request and releases the arbiter. It also
//   flags grant-protocol violations.
//
// Ports:
//   clock, reset_n         single clock; asynchronous active-low reset
//   gnt_0, gnt_1           grants from the arbiter (expected one-hot)
//   data_x, valid_x        per-master beat data / valid
//   ready_x                per-master ready; beat accepted on valid_x && ready_x
//   out_data, out_valid    shared output beat (registered, single entry)
//   out_ready              shared sink ready
//   done_0, done_1         burst complete for the owner (level while in DONE)
//   busy                   transfer in progress (state != IDLE)
//   abort_err              1-cycle pulse: owner's grant lost mid-burst
//   gnt_err                1-cycle pulse: both grants sampled high
// -----------------------------------------------------------------------------
module grant_burst_mux #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [DATA_W-1:0] data_0,
    input  logic              valid_0,
    output logic              ready_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic              valid_1,
    output logic              ready_1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done_0,
    output logic              done_1,
    output logic              busy,
    output logic              abort_err,
    output logic              gnt_err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_abort_err;
    logic                r_gnt_err;

    logic                w_own_gnt;
    logic                w_own_valid;
    logic [DATA_W-1:0]   w_own_data;
    logic                w_both_gnt;
    logic                w_slot_free;
    logic                w_xfer;
    logic                w_accept;
    logic                w_last_accept;

    // Owner-side views of the two masters.
    assign w_own_gnt   = r_owner ? gnt_1   : gnt_0;
    assign w_own_valid = r_owner ? valid_1 : valid_0;
    assign w_own_data  = r_owner ? data_1  : data_0;
    assign w_both_gnt  = gnt_0 && gnt_1;

    // The single-entry output register can take a new beat if it is empty or
    // is being emptied this very cycle; this is what gives 1 beat/cycle.
    assign w_slot_free   = !r_out_valid || out_ready;
    assign w_xfer        = (r_state == ST_XFER);
    assign w_accept      = w_xfer && w_own_valid && w_slot_free;
    assign w_last_accept = w_accept && (r_beat_cnt == LAST_BEAT);

    assign ready_0   = w_xfer && !r_owner && w_slot_free;
    assign ready_1   = w_xfer &&  r_owner && w_slot_free;
    assign done_0    = (r_state == ST_DONE) && !r_owner;
    assign done_1    = (r_state == ST_DONE) &&  r_owner;
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign abort_err = r_abort_err;
    assign gnt_err   = r_gnt_err;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking assignments would make the result
    // depend on statement order and mismatch simulation against synthesis.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_beat_cnt  <= '0;
            // NOTE: the data register is reset too, because out_data must read
            // 0 during reset; a datapath register that is only qualified by a
            // valid bit would normally be left without reset.
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_abort_err <= 1'b0;
            r_gnt_err   <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses.
            r_abort_err <= 1'b0;
            r_gnt_err   <= 1'b0;

            // Output register: load on accept, otherwise drain on out_ready.
            // It runs in every state so a beat left over from an aborted or
            // finished burst still drains after the FSM has moved on.
            if (w_accept) begin
                r_out_data  <= w_own_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_both_gnt) begin
                        r_gnt_err <= 1'b1;
                    end else if (gnt_0) begin
                        r_state <= ST_XFER;
                        r_owner <= 1'b0;
                    end else if (gnt_1) begin
                        r_state <= ST_XFER;
                        r_owner <= 1'b1;
                    end
                end

                ST_XFER: begin
                    // The last beat wins over a simultaneous grant loss: the
                    // burst is complete, and DONE waits for the grant to drop.
                    if (w_last_accept) begin
                        r_state    <= ST_DONE;
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end else if (!w_own_gnt || w_both_gnt) begin
                        // A non-final beat accepted on this same edge has
                        // already been handed over by the master, so it is
                        // kept in the output register and drains normally.
                        r_state    <= ST_IDLE;
                        r_beat_cnt <= '0;
                        if (w_both_gnt) begin
                            r_gnt_err <= 1'b1;
                        end else begin
                            r_abort_err <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // Holding here until the grant falls stops a stale grant
                    // from immediately starting a second burst.
                    if (!w_own_gnt && w_slot_free) begin
                        r_state    <= ST_IDLE;
                        r_beat_cnt <= '0;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
